eth_rx: RTL and testbench

- 10BASE-T Manchester receiver; the receive-side counterpart of eth_tx.
- Samples the serial line `rx` with an oversampling clock and recovers mid-bit transitions.
- Hunts preamble/SFD, then delivers payload bytes LSB-first with a valid strobe.
- On carrier loss, reports frame end with FCS (CRC-32) status and byte count. Feeds the MAC-side frame consumer.

---
 rtl/eth_rx.sv | 170 +++++++++++++++++
 tb/tb_eth_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx.sv
// 10BASE-T Manchester receiver: oversampled mid-bit recovery, preamble/SFD hunt,
// LSB-first byte delivery and CRC-32 frame status reported on carrier loss.
module eth_rx #(
    parameter int SPB          = 8,
    parameter int PREAMBLE_MIN = 16,
    parameter int MIN_LEN      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [10:0] rx_len,
    output logic        rx_busy
);
    localparam int TIMEOUT = SPB + SPB / 2;
    localparam int MID_MIN = 3 * SPB / 4;
    localparam int CW      = $clog2(TIMEOUT + 1);
    localparam int AW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_MAX     = 11'h7FF;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [AW-1:0] alt_cnt;
    logic          last_bit;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [31:0]   crc;
    logic [31:0]   crc_snap;
    logic [10:0]   len;
    logic          first_byte;

    logic          line_edge;
    logic          accept;
    logic          bit_in;
    logic          loss;
    logic [31:0]   crc_next;
    logic [7:0]    byte_next;

    // cnt is reloaded with 1 on an accepted edge, so at the next edge it equals the spacing
    assign line_edge = rx_sync ^ rx_prev;
    assign accept    = line_edge && ((state == IDLE) || (cnt >= CW'(MID_MIN)));
    assign bit_in    = rx_sync;
    assign loss      = !accept && (cnt == CW'(TIMEOUT - 1));
    assign crc_next  = {1'b0, crc[31:1]} ^ ((crc[0] ^ bit_in) ? CRC_POLY : 32'h0);
    assign byte_next = {bit_in, shreg[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rx_meta    <= 1'b0;
            rx_sync    <= 1'b0;
            rx_prev    <= 1'b0;
            cnt        <= '0;
            alt_cnt    <= '0;
            last_bit   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            crc        <= 32'hFFFFFFFF;
            crc_snap   <= 32'hFFFFFFFF;
            len        <= '0;
            first_byte <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_crc_ok  <= 1'b0;
            rx_err     <= 1'b0;
            rx_len     <= '0;
            rx_busy    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;

            if (accept) begin
                cnt <= CW'(1);
            end else if (cnt != CW'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= PRE;
                        rx_busy  <= 1'b1;
                        alt_cnt  <= AW'(1);
                        last_bit <= bit_in;
                    end
                end
                PRE: begin
                    if (accept) begin
                        last_bit <= bit_in;
                        if (bit_in != last_bit) begin
                            if (alt_cnt < AW'(PREAMBLE_MIN)) begin
                                alt_cnt <= alt_cnt + 1'b1;
                            end
                        end else if (bit_in && (alt_cnt >= AW'(PREAMBLE_MIN))) begin
                            state      <= DATA;
                            crc        <= 32'hFFFFFFFF;
                            crc_snap   <= 32'hFFFFFFFF;
                            bit_cnt    <= '0;
                            len        <= '0;
                            first_byte <= 1'b1;
                        end else begin
                            state   <= DROP;
                            rx_busy <= 1'b0;
                        end
                    end else if (loss) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        shreg   <= byte_next;
                        crc     <= crc_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        // Byte boundary: the snapshot keeps dribble bits out of the FCS check
                        if (bit_cnt == 3'd7) begin
                            rx_data    <= byte_next;
                            rx_valid   <= 1'b1;
                            rx_sof     <= first_byte;
                            first_byte <= 1'b0;
                            crc_snap   <= crc_next;
                            if (len != LEN_MAX) begin
                                len <= len + 1'b1;
                            end
                            if (first_byte) begin
                                rx_crc_ok <= 1'b0;
                                rx_err    <= 1'b0;
                                rx_len    <= '0;
                            end
                        end
                    end else if (loss) begin
                        state     <= IDLE;
                        rx_busy   <= 1'b0;
                        rx_eof    <= 1'b1;
                        rx_crc_ok <= (crc_snap == CRC_RESIDUE);
                        rx_err    <= (len < 11'(MIN_LEN));
                        rx_len    <= len;
                    end
                end
                DROP: begin
                    if (loss) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx.sv
// Directed bench for eth_rx: Manchester line driver plus a byte/frame-level
// expectation model (queues of sent bytes, CRC-32 of the payload vs. its FCS).
module tb_eth_rx;
    localparam int SPB = 8;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int   len;
        logic ok;
        logic err;
    } eof_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_crc_ok;
    logic        rx_err;
    logic [10:0] rx_len;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;
    int valid_count = 0;
    int sof_count = 0;
    int eof_count = 0;

    logic [7:0]  exp_data[$];
    logic        exp_sof[$];
    eof_t        exp_eof[$];
    logic        held_ok = 1'b0;
    logic        held_err = 1'b0;
    logic [10:0] held_len = '0;
    logic [7:0]  want_data;
    logic        want_sof;
    eof_t        want_eof;

    byte_q_t     frame;
    logic        bits[$];

    eth_rx #(.SPB(SPB), .PREAMBLE_MIN(16), .MIN_LEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .rx_len(rx_len), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] crc32(input byte_q_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Frame status from the delivered bytes: the last four bytes must equal the payload's FCS
    function automatic eof_t frame_status(input byte_q_t d);
        eof_t s;
        int   n;
        n     = d.size();
        s.len = (n > 2047) ? 2047 : n;
        s.err = (n < 64);
        s.ok  = 1'b0;
        if (n >= 4) begin
            s.ok = (crc32(d, n - 4) == {d[n-1], d[n-2], d[n-3], d[n-4]});
        end
        return s;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] fcs;
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(8'(i * 7 + 3));
        fcs = crc32(frame, n);
        for (int k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
    endtask

    task automatic build_bits(input int n_alt, input int n_bytes, input int n_extra);
        bits.delete();
        for (int i = 0; i < n_alt; i++) bits.push_back(i % 2 == 0);
        bits.push_back(1'b1);
        bits.push_back(1'b1);
        for (int i = 0; i < n_bytes; i++) begin
            for (int b = 0; b < 8; b++) bits.push_back(frame[i][b]);
        end
        for (int e = 0; e < n_extra; e++) bits.push_back(e % 2 == 0);
    endtask

    task automatic expect_frame(input int nbytes, input logic with_eof);
        for (int i = 0; i < nbytes; i++) begin
            exp_data.push_back(frame[i]);
            exp_sof.push_back(i == 0);
        end
        if (with_eof) exp_eof.push_back(frame_status(frame));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The second half-bit is always SPB/2 long, so jittered periods move the mid-bit edges
    task automatic send_bits(input int first, input int last, input logic jitter);
        for (int i = first; i < last; i++) begin
            int p;
            p = jitter ? ((i % 2 == 1) ? 9 : 7) : SPB;
            rx = ~bits[i];
            wait_clks(p - SPB / 2);
            rx = bits[i];
            wait_clks(SPB / 2);
        end
    endtask

    task automatic line_idle();
        wait_clks(3 * SPB);
        rx = 1'b0;
        wait_clks(3 * SPB);
    endtask

    task automatic apply_stimulus(input logic jitter);
        send_bits(0, bits.size(), jitter);
        line_idle();
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid) begin
                valid_count++;
                check_output("eof_with_valid", 32'(rx_eof), 32'd0);
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_byte: got 0x%0h, expected no byte", rx_data);
                end else begin
                    want_data = exp_data.pop_front();
                    want_sof  = exp_sof.pop_front();
                    check_output("rx_data", 32'(rx_data), 32'(want_data));
                    check_output("rx_sof", 32'(rx_sof), 32'(want_sof));
                    if (want_sof) begin
                        held_ok  = 1'b0;
                        held_err = 1'b0;
                        held_len = '0;
                    end
                    check_output("held_status", 32'({rx_crc_ok, rx_err, rx_len}),
                                 32'({held_ok, held_err, held_len}));
                end
            end else if (rx_sof) begin
                check_output("sof_without_valid", 32'(rx_valid), 32'd1);
            end
            if (rx_sof) sof_count++;
            if (rx_eof) begin
                eof_count++;
                if (exp_eof.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_eof: got len %0d, expected no eof", rx_len);
                end else begin
                    want_eof = exp_eof.pop_front();
                    check_output("eof_len", 32'(rx_len), 32'(want_eof.len));
                    check_output("eof_crc_ok", 32'(rx_crc_ok), 32'(want_eof.ok));
                    check_output("eof_err", 32'(rx_err), 32'(want_eof.err));
                    held_ok  = want_eof.ok;
                    held_err = want_eof.err;
                    held_len = 11'(want_eof.len);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        check_output({name, "_pending_bytes"}, 32'(exp_data.size()), 32'd0);
        check_output({name, "_pending_eof"}, 32'(exp_eof.size()), 32'd0);
    endtask

    initial begin
        int v0;
        int s0;
        int e0;
        rst_n = 1'b1;
        rx    = 1'b0;
        #2 rst_n = 1'b0;
        wait_clks(4);
        check_output("reset_outputs",
                     32'({rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len, rx_busy}), 32'd0);
        rst_n = 1'b1;
        wait_clks(60);
        check_output("idle_busy", 32'(rx_busy), 32'd0);
        check_output("idle_no_bytes", 32'(valid_count), 32'd0);

        frame.delete();
        for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
        check_output("model_crc_check_value", crc32(frame, 9), 32'hCBF43926);

        $display("[TB] test 1: good 64-byte frame");
        build_frame(60);
        build_bits(62, 64, 0);
        v0 = valid_count;
        s0 = sof_count;
        expect_frame(64, 1'b1);
        apply_stimulus(1'b0);
        check_drained("t1");
        check_output("t1_valid_strobes", 32'(valid_count - v0), 32'd64);
        check_output("t1_sof_strobes", 32'(sof_count - s0), 32'd1);
        check_output("t1_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b1, 1'b0, 11'd64}));

        $display("[TB] test 2: corrupted payload byte 10");
        build_frame(60);
        frame[10][3] = ~frame[10][3];
        build_bits(62, 64, 0);
        expect_frame(64, 1'b1);
        apply_stimulus(1'b0);
        check_drained("t2");
        check_output("t2_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b0, 1'b0, 11'd64}));

        $display("[TB] test 3: short preamble is dropped");
        build_frame(60);
        build_bits(12, 64, 0);
        v0 = valid_count;
        e0 = eof_count;
        fork
            apply_stimulus(1'b0);
            begin
                wait_clks(300);
                check_output("t3_drop_busy", 32'(rx_busy), 32'd0);
            end
        join
        check_output("t3_no_bytes", 32'(valid_count - v0), 32'd0);
        check_output("t3_no_eof", 32'(eof_count - e0), 32'd0);
        check_output("t3_status_held", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b0, 1'b0, 11'd64}));
        build_bits(62, 64, 0);
        expect_frame(64, 1'b1);
        apply_stimulus(1'b0);
        check_drained("t3");
        check_output("t3_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b1, 1'b0, 11'd64}));

        $display("[TB] test 4: 20-byte runt with good FCS");
        build_frame(16);
        build_bits(62, 20, 0);
        expect_frame(20, 1'b1);
        apply_stimulus(1'b0);
        check_drained("t4");
        check_output("t4_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b1, 1'b1, 11'd20}));

        $display("[TB] test 5: 7/9 sample jitter with dribble bits");
        build_frame(60);
        build_bits(62, 64, 3);
        expect_frame(64, 1'b1);
        apply_stimulus(1'b1);
        check_drained("t5");
        check_output("t5_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b1, 1'b0, 11'd64}));

        $display("[TB] empty frame after SFD");
        frame.delete();
        build_bits(62, 0, 0);
        s0 = sof_count;
        expect_frame(0, 1'b1);
        apply_stimulus(1'b0);
        check_drained("empty");
        check_output("empty_no_sof", 32'(sof_count - s0), 32'd0);
        check_output("empty_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b0, 1'b1, 11'd0}));

        $display("[TB] test 6: reset during payload byte 30");
        build_frame(60);
        build_bits(62, 64, 0);
        expect_frame(30, 1'b0);
        e0 = eof_count;
        send_bits(0, 64 + 30 * 8 + 1, 1'b0);
        check_output("t6_busy_in_data", 32'(rx_busy), 32'd1);
        fork
            begin
                send_bits(64 + 30 * 8 + 1, bits.size(), 1'b0);
                line_idle();
            end
            begin
                rst_n    = 1'b0;
                held_ok  = 1'b0;
                held_err = 1'b0;
                held_len = '0;
                wait_clks(2);
                check_output("t6_reset_outputs",
                             32'({rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len, rx_busy}), 32'd0);
                wait_clks(1);
                rst_n = 1'b1;
            end
        join
        check_drained("t6_abort");
        check_output("t6_no_eof", 32'(eof_count - e0), 32'd0);
        build_bits(62, 64, 0);
        expect_frame(64, 1'b1);
        apply_stimulus(1'b0);
        check_drained("t6");
        check_output("t6_status", 32'({rx_crc_ok, rx_err, rx_len}), 32'({1'b1, 1'b0, 11'd64}));
        check_output("final_busy", 32'(rx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
